// File: rtl/pe_mac_pipe.sv
// Systolic-array PE: forwards A/B east/south and runs a 2-stage MAC over first/last tagged streams.
// Optional: define PE_SAT_EN for a saturating accumulator with a per-stream sticky ovf flag.
module pe_mac_pipe #(
  parameter int DW     = 8,
  parameter int ACCW   = 32,
  parameter int SIGNED = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [DW-1:0]   a_in,
  input  logic            a_vld_in,
  input  logic [DW-1:0]   b_in,
  input  logic            b_vld_in,
  input  logic            first_in,
  input  logic            last_in,
  output logic [DW-1:0]   a_out,
  output logic            a_vld_out,
  output logic            first_out,
  output logic            last_out,
  output logic [DW-1:0]   b_out,
  output logic            b_vld_out,
  output logic [ACCW-1:0] c_out,
  output logic            c_vld,
  output logic            skew_err,
  output logic            ovf
);

  localparam int PW = 2 * DW;

  if (ACCW < PW) begin : g_accw_check
    $error("pe_mac_pipe: ACCW (%0d) must be >= 2*DW (%0d)", ACCW, PW);
  end

  logic          fire;
  logic          a_sx;
  logic          b_sx;
  logic [PW-1:0] a_ext;
  logic [PW-1:0] b_ext;
  logic [PW-1:0] prod;

  // The low 2*DW bits of a product of extended operands are the exact signed/unsigned result.
  assign fire  = a_vld_in & b_vld_in;
  assign a_sx  = (SIGNED != 0) & a_in[DW-1];
  assign b_sx  = (SIGNED != 0) & b_in[DW-1];
  assign a_ext = {{DW{a_sx}}, a_in};
  assign b_ext = {{DW{b_sx}}, b_in};
  assign prod  = a_ext * b_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out     <= '0;
      a_vld_out <= 1'b0;
      first_out <= 1'b0;
      last_out  <= 1'b0;
      b_out     <= '0;
      b_vld_out <= 1'b0;
    end else if (en) begin
      a_out     <= a_in;
      a_vld_out <= a_vld_in;
      first_out <= first_in;
      last_out  <= last_in;
      b_out     <= b_in;
      b_vld_out <= b_vld_in;
    end
  end

  logic [PW-1:0] p;
  logic          p_vld;
  logic          p_first;
  logic          p_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p       <= '0;
      p_vld   <= 1'b0;
      p_first <= 1'b0;
      p_last  <= 1'b0;
    end else if (en) begin
      p       <= prod;
      p_vld   <= fire;
      p_first <= fire & first_in;
      p_last  <= fire & last_in;
    end
  end

  logic [ACCW-1:0] p_ext;
  logic [ACCW-1:0] acc;
  logic [ACCW-1:0] acc_base;
  logic [ACCW-1:0] acc_next;

  // A first beat restarts the sum, so it adds onto zero instead of the old accumulator.
  always_comb begin
    p_ext    = (SIGNED != 0) ? ACCW'($signed(p)) : ACCW'(p);
    acc_base = p_first ? '0 : acc;
  end

`ifdef PE_SAT_EN
  logic [ACCW:0]   sum_wide;
  logic [ACCW-1:0] sat_val;
  logic            sat_hit;
  logic            ovf_q;

  always_comb begin
    sum_wide = {1'b0, acc_base} + {1'b0, p_ext};
    if (SIGNED != 0) begin
      sat_hit = (acc_base[ACCW-1] == p_ext[ACCW-1]) && (sum_wide[ACCW-1] != acc_base[ACCW-1]);
      sat_val = {acc_base[ACCW-1], {(ACCW-1){~acc_base[ACCW-1]}}};
    end else begin
      sat_hit = sum_wide[ACCW];
      sat_val = '1;
    end
    acc_next = sat_hit ? sat_val : sum_wide[ACCW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (en && p_vld) begin
      ovf_q <= (~p_first & ovf_q) | sat_hit;
    end
  end

  assign ovf = ovf_q;
`else
  always_comb begin
    acc_next = acc_base + p_ext;
  end

  assign ovf = 1'b0;
`endif

  // c_vld is only re-evaluated on advancing edges so a stall stretches the pulse with the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      c_out    <= '0;
      c_vld    <= 1'b0;
      skew_err <= 1'b0;
    end else if (en) begin
      if (p_vld) begin
        acc <= acc_next;
        if (p_last) begin
          c_out <= acc_next;
        end
      end
      c_vld <= p_vld & p_last;
      if (a_vld_in ^ b_vld_in) begin
        skew_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pe_mac_pipe.sv
// Directed testbench for pe_mac_pipe: unsigned 32-bit, signed 32-bit and unsigned 16-bit instances share stimulus.
// Expectations for the 16-bit instance follow PE_SAT_EN when the bench is built with it.
module tb_pe_mac_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [7:0]  a_in, b_in;
  logic        a_vld_in, b_vld_in, first_in, last_in;

  logic [7:0]  a_out, b_out;
  logic        a_vld_out, b_vld_out, first_out, last_out, c_vld, skew_err, ovf;
  logic [31:0] c_out;

  logic [7:0]  s_a_out, s_b_out;
  logic        s_a_vld_out, s_b_vld_out, s_first_out, s_last_out, s_c_vld, s_skew_err, s_ovf;
  logic [31:0] s_c_out;

  logic [7:0]  w_a_out, w_b_out;
  logic        w_a_vld_out, w_b_vld_out, w_first_out, w_last_out, w_c_vld, w_skew_err, w_ovf;
  logic [15:0] w_c_out;

  int checks = 0;
  int errors = 0;

  localparam logic [15:0] W_WRAP = 16'((32'd255 * 32'd255) * 2);

  always #5 clk = ~clk;

  pe_mac_pipe #(.DW(8), .ACCW(32), .SIGNED(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .a_in(a_in), .a_vld_in(a_vld_in), .b_in(b_in), .b_vld_in(b_vld_in),
    .first_in(first_in), .last_in(last_in),
    .a_out(a_out), .a_vld_out(a_vld_out), .first_out(first_out), .last_out(last_out),
    .b_out(b_out), .b_vld_out(b_vld_out),
    .c_out(c_out), .c_vld(c_vld), .skew_err(skew_err), .ovf(ovf)
  );

  pe_mac_pipe #(.DW(8), .ACCW(32), .SIGNED(1)) u_sgn (
    .clk(clk), .rst_n(rst_n), .en(en),
    .a_in(a_in), .a_vld_in(a_vld_in), .b_in(b_in), .b_vld_in(b_vld_in),
    .first_in(first_in), .last_in(last_in),
    .a_out(s_a_out), .a_vld_out(s_a_vld_out), .first_out(s_first_out), .last_out(s_last_out),
    .b_out(s_b_out), .b_vld_out(s_b_vld_out),
    .c_out(s_c_out), .c_vld(s_c_vld), .skew_err(s_skew_err), .ovf(s_ovf)
  );

  pe_mac_pipe #(.DW(8), .ACCW(16), .SIGNED(0)) u_w16 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .a_in(a_in), .a_vld_in(a_vld_in), .b_in(b_in), .b_vld_in(b_vld_in),
    .first_in(first_in), .last_in(last_in),
    .a_out(w_a_out), .a_vld_out(w_a_vld_out), .first_out(w_first_out), .last_out(w_last_out),
    .b_out(w_b_out), .b_vld_out(w_b_vld_out),
    .c_out(w_c_out), .c_vld(w_c_vld), .skew_err(w_skew_err), .ovf(w_ovf)
  );

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic av, input logic bv,
                       input logic f, input logic l);
    a_in = a; b_in = b; a_vld_in = av; b_vld_in = bv; first_in = f; last_in = l;
  endtask

  task automatic idle();
    drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Inputs change and outputs are sampled on the falling edge, away from the active edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; idle();
    #12;
    checks++;
    if ({c_out, c_vld, a_out, b_out, a_vld_out, b_vld_out, first_out, last_out, skew_err, ovf} !== '0) begin
      errors++; $display("[TB] FAIL reset_main: got c_out=%h c_vld=%b a_out=%h b_out=%h skew=%b expected all zero",
                         c_out, c_vld, a_out, b_out, skew_err);
    end
    checks++;
    if ({s_c_out, w_c_out, s_c_vld, w_c_vld, w_ovf} !== '0) begin
      errors++; $display("[TB] FAIL reset_others: got s_c_out=%h w_c_out=%h w_ovf=%b expected zero",
                         s_c_out, w_c_out, w_ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_no_first();
    drive(8'd3, 8'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    tick(); idle();
    checks++;
    if (c_vld !== 1'b0) begin errors++; $display("[TB] FAIL nofirst_early: got c_vld=%b expected 0", c_vld); end
    tick();
    checks++;
    if (c_vld !== 1'b1 || c_out !== 32'd9) begin
      errors++; $display("[TB] FAIL nofirst_result: got c_vld=%b c_out=%0d expected 1/9", c_vld, c_out);
    end
    tick();
    checks++;
    if (c_vld !== 1'b0) begin errors++; $display("[TB] FAIL nofirst_pulse: got c_vld=%b expected 0", c_vld); end
  endtask

  task automatic test_forwarding();
    drive(8'hA5, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); idle();
    checks++;
    if (a_out !== 8'hA5 || b_out !== 8'h3C || a_vld_out !== 1'b1 || b_vld_out !== 1'b1) begin
      errors++; $display("[TB] FAIL forward: got a=%h b=%h av=%b bv=%b expected A5/3C/1/1",
                         a_out, b_out, a_vld_out, b_vld_out);
    end
    checks++;
    if (skew_err !== 1'b0) begin errors++; $display("[TB] FAIL forward_skew: got %b expected 0", skew_err); end
    tick();
  endtask

  task automatic test_mac();
    drive(8'd3, 8'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    checks++;
    if (first_out !== 1'b1 || last_out !== 1'b0) begin
      errors++; $display("[TB] FAIL mac_first_fwd: got first=%b last=%b expected 1/0", first_out, last_out);
    end
    drive(8'd5, 8'd6, 1'b1, 1'b1, 1'b0, 1'b1);
    tick(); idle();
    checks++;
    if (last_out !== 1'b1 || c_vld !== 1'b0) begin
      errors++; $display("[TB] FAIL mac_mid: got last_out=%b c_vld=%b expected 1/0", last_out, c_vld);
    end
    tick();
    checks++;
    if (c_vld !== 1'b1 || c_out !== 32'd42) begin
      errors++; $display("[TB] FAIL mac_result: got c_vld=%b c_out=%0d expected 1/42", c_vld, c_out);
    end
    tick();
    checks++;
    if (c_vld !== 1'b0 || c_out !== 32'd42) begin
      errors++; $display("[TB] FAIL mac_hold: got c_vld=%b c_out=%0d expected 0/42", c_vld, c_out);
    end
  endtask

  task automatic test_signed();
    drive(8'hFD, 8'h07, 1'b1, 1'b1, 1'b1, 1'b1);
    tick(); idle(); tick();
    checks++;
    if (s_c_vld !== 1'b1 || s_c_out !== 32'hFFFF_FFEB) begin
      errors++; $display("[TB] FAIL signed_single: got c_vld=%b c_out=%h expected 1/FFFFFFEB", s_c_vld, s_c_out);
    end
    checks++;
    if (c_out !== 32'd1771) begin errors++; $display("[TB] FAIL unsigned_single: got %0d expected 1771", c_out); end
    // -3*7 + -2*-5 = -11 signed; 253*7 + 254*251 = 65525 unsigned
    drive(8'hFD, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    drive(8'hFE, 8'hFB, 1'b1, 1'b1, 1'b0, 1'b1);
    tick(); idle(); tick();
    checks++;
    if (s_c_out !== 32'hFFFF_FFF5) begin errors++; $display("[TB] FAIL signed_two: got %h expected FFFFFFF5", s_c_out); end
    checks++;
    if (c_out !== 32'd65525) begin errors++; $display("[TB] FAIL unsigned_two: got %0d expected 65525", c_out); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  va [5]  = '{8'd2, 8'd4, 8'd6, 8'd1, 8'd2};
    logic [7:0]  vb [5]  = '{8'd3, 8'd5, 8'd7, 8'd1, 8'd2};
    logic        vf [5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        vl [5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic        ev [6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] eo [6]  = '{32'd65525, 32'd26, 32'd42, 32'd42, 32'd5, 32'd5};
    drive(va[0], vb[0], 1'b1, 1'b1, vf[0], vl[0]);
    tick();
    for (int k = 0; k < 6; k++) begin
      if (k + 1 < 5) drive(va[k+1], vb[k+1], 1'b1, 1'b1, vf[k+1], vl[k+1]);
      else idle();
      tick();
      checks++;
      if (c_vld !== ev[k] || c_out !== eo[k]) begin
        errors++; $display("[TB] FAIL b2b_cycle%0d: got c_vld=%b c_out=%0d expected %b/%0d", k, c_vld, c_out, ev[k], eo[k]);
      end
    end
  endtask

  task automatic test_drop();
    drive(8'd3, 8'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    drive(8'd9, 8'd9, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    drive(8'd1, 8'd1, 1'b1, 1'b1, 1'b0, 1'b1);
    tick(); idle();
    checks++;
    if (c_vld !== 1'b0) begin errors++; $display("[TB] FAIL drop_tag: got c_vld=%b expected 0", c_vld); end
    tick();
    checks++;
    if (c_vld !== 1'b1 || c_out !== 32'd10) begin
      errors++; $display("[TB] FAIL drop_result: got c_vld=%b c_out=%0d expected 1/10", c_vld, c_out);
    end
    tick();
  endtask

  task automatic test_stall();
    drive(8'd3, 8'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    en = 1'b0;
    drive(8'd5, 8'd6, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (a_out !== 8'd3 || b_out !== 8'd4 || first_out !== 1'b1 || c_vld !== 1'b0) begin
        errors++; $display("[TB] FAIL stall_freeze%0d: got a=%0d b=%0d first=%b c_vld=%b expected 3/4/1/0",
                           k, a_out, b_out, first_out, c_vld);
      end
    end
    en = 1'b1;
    tick(); idle();
    checks++;
    if (a_out !== 8'd5 || c_vld !== 1'b0) begin
      errors++; $display("[TB] FAIL stall_resume: got a=%0d c_vld=%b expected 5/0", a_out, c_vld);
    end
    tick();
    checks++;
    if (c_vld !== 1'b1 || c_out !== 32'd42) begin
      errors++; $display("[TB] FAIL stall_result: got c_vld=%b c_out=%0d expected 1/42", c_vld, c_out);
    end
    en = 1'b0;
    tick();
    checks++;
    if (c_vld !== 1'b1) begin errors++; $display("[TB] FAIL stall_stretch: got c_vld=%b expected 1", c_vld); end
    en = 1'b1;
    tick();
    checks++;
    if (c_vld !== 1'b0) begin errors++; $display("[TB] FAIL stall_release: got c_vld=%b expected 0", c_vld); end
  endtask

  task automatic test_saturation();
    logic [15:0] exp_c;
    logic        exp_ovf;
`ifdef PE_SAT_EN
    exp_c = 16'hFFFF; exp_ovf = 1'b1;
`else
    exp_c = W_WRAP;   exp_ovf = 1'b0;
`endif
    drive(8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    drive(8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1);
    tick(); idle(); tick();
    checks++;
    if (w_c_vld !== 1'b1 || w_c_out !== exp_c || w_ovf !== exp_ovf) begin
      errors++; $display("[TB] FAIL sat16: got c_vld=%b c_out=%h ovf=%b expected 1/%h/%b", w_c_vld, w_c_out, w_ovf, exp_c, exp_ovf);
    end
    checks++;
    if (c_out !== 32'h0001_FC02 || ovf !== 1'b0) begin
      errors++; $display("[TB] FAIL sat32_nowrap: got c_out=%h ovf=%b expected 0001FC02/0", c_out, ovf);
    end
    drive(8'd1, 8'd1, 1'b1, 1'b1, 1'b1, 1'b1);
    tick(); idle(); tick();
    checks++;
    if (w_c_out !== 16'd1 || w_ovf !== 1'b0) begin
      errors++; $display("[TB] FAIL sat16_clear: got c_out=%h ovf=%b expected 0001/0", w_c_out, w_ovf);
    end
  endtask

  task automatic test_skew();
    drive(8'd1, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); idle();
    checks++;
    if (skew_err !== 1'b1) begin errors++; $display("[TB] FAIL skew_set: got %b expected 1", skew_err); end
    tick();
    checks++;
    if (skew_err !== 1'b1) begin errors++; $display("[TB] FAIL skew_sticky: got %b expected 1", skew_err); end
  endtask

  task automatic test_reset_mid();
    drive(8'd7, 8'd7, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    drive(8'd1, 8'd1, 1'b1, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({c_out, c_vld, a_out, b_out, a_vld_out, last_out, skew_err} !== '0 || s_c_out !== 32'd0) begin
      errors++; $display("[TB] FAIL reset_async: got c_out=%h a_out=%h b_out=%h last=%b skew=%b s_c_out=%h expected zero",
                         c_out, a_out, b_out, last_out, skew_err, s_c_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(8'd2, 8'd2, 1'b1, 1'b1, 1'b1, 1'b1);
    tick(); idle(); tick();
    checks++;
    if (c_vld !== 1'b1 || c_out !== 32'd4) begin
      errors++; $display("[TB] FAIL reset_restart: got c_vld=%b c_out=%0d expected 1/4", c_vld, c_out);
    end
  endtask

  initial begin
    test_reset();
    test_no_first();
    test_forwarding();
    test_mac();
    test_signed();
    test_back_to_back();
    test_drop();
    test_stall();
    test_saturation();
    test_skew();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
